// File: rtl/dac_pkg.sv
// Shared types, defaults and the sample conversion helper for the SPI DAC serializer.
package dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } dac_state_e;

  localparam int unsigned             DEF_DATA_W    = 12;
  localparam int unsigned             DEF_CTRL_W    = 4;
  localparam logic [DEF_CTRL_W-1:0]   DEF_CTRL_WORD = 4'b0000;
  localparam int unsigned             FRAME_W       = DEF_CTRL_W + DEF_DATA_W;

  // Two's complement to offset binary is a flip of the sample MSB.
  function automatic logic [31:0] to_offset_bin(input logic [31:0] s,
                                                input int unsigned w,
                                                input bit signed_in);
    logic [31:0] msb;
    msb = 32'd1 << (w - 1);
    return signed_in ? (s ^ msb) : s;
  endfunction

endpackage

// File: rtl/dac_spi_serializer_if.sv
// Sample handshake between the upstream filter and the DAC serializer.
interface dac_spi_serializer_if
  import dac_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;

  modport master (output sample_in, output sample_valid, input  sample_ready);
  modport slave  (input  sample_in, input  sample_valid, output sample_ready);
endinterface

// File: rtl/dac_sclk_gen.sv
// SCLK generator: toggles every HALF_PER cycles while enabled, idles low otherwise.
module dac_sclk_gen #(
  parameter int unsigned HALF_PER = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise_pulse,
  output logic o_fall_pulse
);
  localparam int unsigned      CNT_W = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(HALF_PER - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_wrap;

  assign w_wrap       = i_en && (r_cnt == LAST);
  // Pulses flag the clock edge at which r_sclk is about to change.
  assign o_rise_pulse = w_wrap && !r_sclk;
  assign o_fall_pulse = w_wrap && r_sclk;
  assign o_sclk       = r_sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_spi_serializer.sv
// Converts filtered samples to offset binary and ships them as CTRL+DATA frames
// to an SPI DAC (CPOL=0), with a one-entry holding register in front.
module dac_spi_serializer
  import dac_pkg::*;
#(
  parameter int unsigned          DATA_W    = DEF_DATA_W,
  parameter int unsigned          CTRL_W    = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0]    CTRL_WORD = DEF_CTRL_WORD,
  parameter int unsigned          HALF_PER  = 2,
  parameter int unsigned          CS_SETUP  = 1,
  parameter int unsigned          CS_GAP    = 2,
  parameter bit                   SIGNED_IN = 1'b1
) (
  input  logic                  dac_clk,
  input  logic                  reset_n,
  dac_spi_serializer_if.slave   s_if,
  output logic                  dac_cs,
  output logic                  dac_sclk,
  output logic                  dac_sdo,
  output logic                  busy,
  output logic [7:0]            overflow_cnt
);
  localparam int unsigned FW    = CTRL_W + DATA_W;
  localparam int unsigned BIT_W = $clog2(FW);
  localparam int unsigned TMR_W = 16;

  dac_state_e        r_state;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_hold_full;
  logic              r_ready;
  logic [7:0]        r_ovf;
  logic [FW-2:0]     r_shift;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_last;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_cs;
  logic              r_sdo;
  logic              r_busy;

  logic              w_drain;
  logic [DATA_W-1:0] w_data;
  logic [FW-1:0]     w_frame;
  logic              w_sclk;
  logic              w_rise;
  logic              w_fall;

  assign w_drain = (r_state == IDLE) && r_hold_full;
  assign w_data  = DATA_W'(to_offset_bin(32'(r_hold_data), DATA_W, SIGNED_IN));
  assign w_frame = {CTRL_WORD, w_data};

  dac_sclk_gen #(
    .HALF_PER (HALF_PER)
  ) u_sclk_gen (
    .clk          (dac_clk),
    .rst_n        (reset_n),
    .i_en         (r_state == SHIFT),
    .o_sclk       (w_sclk),
    .o_rise_pulse (w_rise),
    .o_fall_pulse (w_fall)
  );

  // A new sample always lands; it only counts as overflow if the old one is lost.
  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b1;
      r_ovf       <= '0;
    end else begin
      if (s_if.sample_valid) begin
        r_hold_data <= s_if.sample_in;
        r_hold_full <= 1'b1;
        if (r_hold_full && !w_drain && (r_ovf != 8'hFF))
          r_ovf <= r_ovf + 8'd1;
      end else if (w_drain) begin
        r_hold_full <= 1'b0;
      end
      r_ready <= !(s_if.sample_valid || (r_hold_full && !w_drain));
    end
  end

  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_last    <= 1'b0;
      r_tmr     <= '0;
      r_cs      <= 1'b1;
      r_sdo     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cs   <= 1'b1;
          r_busy <= 1'b0;
          r_sdo  <= 1'b0;
          if (r_hold_full) begin
            r_shift   <= w_frame[FW-2:0];
            r_sdo     <= w_frame[FW-1];
            r_bit_cnt <= BIT_W'(FW - 1);
            r_last    <= 1'b0;
            r_tmr     <= TMR_W'(CS_SETUP - 1);
            r_cs      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (r_tmr == '0) r_state <= SHIFT;
          else             r_tmr   <= r_tmr - 1'b1;
        end
        SHIFT: begin
          // Bit count advances on the rise so the fall already knows it ends the frame.
          if (w_rise) begin
            r_last <= (r_bit_cnt == '0);
            if (r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - 1'b1;
          end
          if (w_fall) begin
            if (r_last) begin
              r_state <= HOLD;
            end else begin
              r_sdo   <= r_shift[FW-2];
              r_shift <= {r_shift[FW-3:0], 1'b0};
            end
          end
        end
        HOLD: begin
          r_cs    <= 1'b1;
          r_sdo   <= 1'b0;
          r_tmr   <= TMR_W'(CS_GAP - 1);
          r_state <= GAP;
        end
        GAP: begin
          if (r_tmr == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_tmr   <= r_tmr - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_if.sample_ready = r_ready;
  assign dac_cs            = r_cs;
  assign dac_sclk          = w_sclk;
  assign dac_sdo           = r_sdo;
  assign busy              = r_busy;
  assign overflow_cnt      = r_ovf;

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Directed bench for dac_spi_serializer: a pin-level SPI monitor rebuilds each frame.
module tb_dac_spi_serializer;

  localparam int unsigned HALF_PER = 2;
  localparam int unsigned CS_GAP   = 2;

  logic       dac_clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       dac_cs;
  logic       dac_sclk;
  logic       dac_sdo;
  logic       busy;
  logic [7:0] overflow_cnt;

  dac_spi_serializer_if #(.DATA_W(12)) s_if ();

  dac_spi_serializer #(
    .DATA_W    (12),
    .CTRL_W    (4),
    .CTRL_WORD (4'b0000),
    .HALF_PER  (HALF_PER),
    .CS_SETUP  (1),
    .CS_GAP    (CS_GAP),
    .SIGNED_IN (1'b1)
  ) dut (
    .dac_clk      (dac_clk),
    .reset_n      (reset_n),
    .s_if         (s_if),
    .dac_cs       (dac_cs),
    .dac_sclk     (dac_sclk),
    .dac_sdo      (dac_sdo),
    .busy         (busy),
    .overflow_cnt (overflow_cnt)
  );

  always #5 dac_clk = ~dac_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin monitor, sampled on the falling clock edge.
  logic [15:0] frames[$];
  int          frame_rises[$];
  logic [15:0] mon_acc      = '0;
  int          mon_rises    = 0;
  bit          mon_in_frame = 1'b0;
  bit          mon_seen     = 1'b0;
  int          mon_hi_run   = 0;
  int          mon_gap_run  = 0;
  int          min_gap      = 1000;
  int          glitches     = 0;
  logic        prev_cs      = 1'b1;
  logic        prev_sclk    = 1'b0;

  initial begin
    forever begin
      @(negedge dac_clk);
      if (!reset_n) begin
        mon_in_frame = 1'b0;
        mon_seen     = 1'b0;
        mon_rises    = 0;
        mon_hi_run   = 0;
        mon_acc      = '0;
      end else begin
        if (dac_sclk && !prev_sclk) begin
          mon_acc = {mon_acc[14:0], dac_sdo};
          mon_rises++;
          if (dac_cs) glitches++;
        end
        if (dac_sclk) begin
          mon_hi_run++;
        end else begin
          if (prev_sclk && (mon_hi_run != HALF_PER)) glitches++;
          mon_hi_run = 0;
        end
        if (!prev_cs && dac_cs && mon_in_frame) begin
          frames.push_back(mon_acc);
          frame_rises.push_back(mon_rises);
          mon_in_frame = 1'b0;
          mon_seen     = 1'b1;
          mon_gap_run  = 1;
        end else if (dac_cs) begin
          mon_gap_run++;
        end
        if (prev_cs && !dac_cs) begin
          if (mon_seen && (mon_gap_run < min_gap)) min_gap = mon_gap_run;
          mon_in_frame = 1'b1;
          mon_acc      = '0;
          mon_rises    = 0;
        end
      end
      prev_cs   = dac_cs;
      prev_sclk = dac_sclk;
    end
  end

  task automatic tick();
    @(posedge dac_clk);
    #1;
  endtask

  task automatic send(input logic [11:0] v);
    s_if.sample_in    = v;
    s_if.sample_valid = 1'b1;
    tick();
    s_if.sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int n);
    int k = 0;
    while ((frames.size() < n) && (k < 1000)) begin
      tick();
      k++;
    end
    check({tag, "_frames"}, 32'(frames.size()), 32'(n));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!(dac_cs && !busy && s_if.sample_ready) && (k < 1000)) begin
      tick();
      k++;
    end
    check({tag, "_idle"}, 32'(dac_cs && !busy && s_if.sample_ready), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [15:0] exp);
    if (idx < frames.size()) begin
      check({tag, "_data"},  32'(frames[idx]), 32'(exp));
      check({tag, "_rises"}, 32'(frame_rises[idx]), 32'd16);
    end else begin
      check({tag, "_missing"}, 32'(frames.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int base;
    int n;
    int k;
    int bad;

    s_if.sample_in    = '0;
    s_if.sample_valid = 1'b0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_cs",    32'(dac_cs),            32'd1);
    check("rst_sclk",  32'(dac_sclk),          32'd0);
    check("rst_sdo",   32'(dac_sdo),           32'd0);
    check("rst_busy",  32'(busy),              32'd0);
    check("rst_ready", 32'(s_if.sample_ready), 32'd1);
    check("rst_ovf",   32'(overflow_cnt),      32'd0);
    repeat (3) @(posedge dac_clk);
    #1 reset_n = 1'b1;
    tick();

    // 1: single sample 0x000 -> frame 0x0800, CS low 66 cycles, busy 68 cycles
    base = frames.size();
    send(12'h000);
    check("t1_ready_after_fill", 32'(s_if.sample_ready), 32'd0);
    check("t1_cs_before",        32'(dac_cs),            32'd1);
    tick();
    check("t1_cs_fall",   32'(dac_cs), 32'd0);
    check("t1_busy_fall", 32'(busy),   32'd1);
    n = 0;
    while (!dac_cs && (n < 200)) begin
      tick();
      n++;
    end
    check("t1_cs_low_cycles", 32'(n), 32'd66);
    while (busy && (n < 200)) begin
      tick();
      n++;
    end
    check("t1_busy_cycles", 32'(n), 32'd68);
    check_frame("t1", base, 16'h0800);
    check("t1_ready_end", 32'(s_if.sample_ready), 32'd1);

    // 2: extremes 0x7FF then 0x800 -> 0x0FFF, 0x0000
    base = frames.size();
    send(12'h7FF);
    repeat (5) tick();
    send(12'h800);
    wait_frames("t2", base + 2);
    check_frame("t2_f0", base,     16'h0FFF);
    check_frame("t2_f1", base + 1, 16'h0000);
    check("t2_gap_min", 32'(min_gap >= CS_GAP), 32'd1);
    check("t2_ovf",     32'(overflow_cnt),      32'd0);
    wait_idle("t2");

    // 3: 0x456 overwrites pending 0x123
    base = frames.size();
    send(12'h001);
    repeat (5) tick();
    send(12'h123);
    repeat (5) tick();
    send(12'h456);
    check("t3_ovf",   32'(overflow_cnt),      32'd1);
    check("t3_ready", 32'(s_if.sample_ready), 32'd0);
    wait_frames("t3", base + 2);
    check_frame("t3_f0", base,     16'h0801);
    check_frame("t3_f1", base + 1, 16'h0C56);
    wait_idle("t3");

    // 4: valid on the drain cycle, no overflow
    base = frames.size();
    send(12'h100);
    send(12'h200);
    check("t4_ready", 32'(s_if.sample_ready), 32'd0);
    check("t4_ovf",   32'(overflow_cnt),      32'd1);
    wait_frames("t4", base + 2);
    check_frame("t4_f0", base,     16'h0900);
    check_frame("t4_f1", base + 1, 16'h0A00);
    wait_idle("t4");
    check("t4_ovf_end", 32'(overflow_cnt), 32'd1);

    // 5: reset after the 7th SCLK rise (bit 9 of 0x02AA is 1 on SDO)
    base = frames.size();
    send(12'h2AA);
    repeat (3) tick();
    send(12'h3AB);
    k = 0;
    while (!(mon_in_frame && (mon_rises >= 7)) && (k < 200)) begin
      tick();
      k++;
    end
    check("t5_reached_rise7", 32'(mon_rises), 32'd7);
    check("t5_pre_sclk",  32'(dac_sclk),          32'd1);
    check("t5_pre_sdo",   32'(dac_sdo),           32'd1);
    check("t5_pre_ready", 32'(s_if.sample_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("t5_cs",    32'(dac_cs),            32'd1);
    check("t5_sclk",  32'(dac_sclk),          32'd0);
    check("t5_sdo",   32'(dac_sdo),           32'd0);
    check("t5_busy",  32'(busy),              32'd0);
    check("t5_ready", 32'(s_if.sample_ready), 32'd1);
    check("t5_ovf",   32'(overflow_cnt),      32'd0);
    repeat (3) @(posedge dac_clk);
    #1 reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (!dac_cs) n++;
    end
    check("t5_no_resume_cs", 32'(n),             32'd0);
    check("t5_no_frames",    32'(frames.size()), 32'(base));

    // 6: 300 back-to-back valids -> overflow saturates
    base = frames.size();
    for (int i = 0; i < 300; i++) begin
      s_if.sample_in    = 12'(i);
      s_if.sample_valid = 1'b1;
      tick();
    end
    s_if.sample_valid = 1'b0;
    wait_idle("t6");
    check("t6_ovf_sat",  32'(overflow_cnt),          32'd255);
    check("t6_n_frames", 32'(frames.size() - base),  32'd6);
    bad = 0;
    for (int i = base; i < frames.size(); i++)
      if (frame_rises[i] != 16) bad++;
    check("t6_bad_rises", 32'(bad), 32'd0);
    check_frame("t6_first", base, 16'h0800);
    check_frame("t6_last",  frames.size() - 1, 16'h092B);
    check("t6_gap_min",      32'(min_gap >= CS_GAP), 32'd1);
    check("sclk_glitches",   32'(glitches),          32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
